// File: rtl/boss_attack_sequencer_if.sv
// Boss attack sequencer bus.
// Groups the step/hit inputs and every geometry/status output of the boss
// attack sequencer. The slave modport is the sequencer's view. The master
// modport is the game core's view: it drives step/hit and consumes the rest.
//   pulse_stepCycle, bossHit       : one-cycle strobes into the sequencer
//   bossLocX/Y, bossWidth/Height   : constant boss box
//   projX/projY/projValid          : per-channel geometry, channel i in row i
//   projW/projH, attackType        : current object size and kind
//   bossShoot, beamWarn            : fire strobe, beam charge indicator
//   bossHP, enraged, bossDead      : health status
interface boss_attack_sequencer_if #(
  parameter int N_PROJ = 5,
  parameter int HP_W   = 10
);
  logic                       pulse_stepCycle;
  logic                       bossHit;
  logic [9:0]                 bossLocX;
  logic [8:0]                 bossLocY;
  logic [9:0]                 bossWidth;
  logic [8:0]                 bossHeight;
  logic [N_PROJ-1:0][9:0]     projX;
  logic [N_PROJ-1:0][8:0]     projY;
  logic [N_PROJ-1:0]          projValid;
  logic [9:0]                 projW;
  logic [8:0]                 projH;
  logic [1:0]                 attackType;
  logic                       bossShoot;
  logic                       beamWarn;
  logic [HP_W-1:0]            bossHP;
  logic                       enraged;
  logic                       bossDead;

  modport slave (
    input  pulse_stepCycle, bossHit,
    output bossLocX, bossLocY, bossWidth, bossHeight,
    output projX, projY, projValid, projW, projH, attackType,
    output bossShoot, beamWarn, bossHP, enraged, bossDead
  );

  modport master (
    output pulse_stepCycle, bossHit,
    input  bossLocX, bossLocY, bossWidth, bossHeight,
    input  projX, projY, projValid, projW, projH, attackType,
    input  bossShoot, beamWarn, bossHP, enraged, bossDead
  );
endinterface

// File: rtl/boss_attack_sequencer.sv
// Boss attack sequencer.
// Cycles the boss through spread A / spread B volleys and a charged beam on
// each step pulse, tracks saturating HP, the enraged flag and death.
// Ports:
//   clk_master : system clock (rising edge only)
//   rst_n      : synchronous active-low reset, overrides all inputs
//   bus        : boss_attack_sequencer_if.slave (strobes in, geometry out)
module boss_attack_sequencer #(
  parameter int N_PROJ     = 5,
  parameter int BOSS_X     = 150,
  parameter int BOSS_Y     = 50,
  parameter int BOSS_W     = 340,
  parameter int BOSS_H     = 150,
  parameter int PROJ_W     = 10,
  parameter int PROJ_H     = 15,
  parameter int BEAM_W     = 50,
  parameter int BEAM_H     = 240,
  parameter int BEAM_DELAY = 25000000,
  parameter int BOSS_HP    = 300,
  parameter int HIT_DMG    = 5,
  parameter int ENRAGE_HP  = 100,
  parameter int HP_W       = 10
) (
  input  logic                  clk_master,
  input  logic                  rst_n,
  boss_attack_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_A1     = 3'd1;
  localparam logic [2:0] S_B1     = 3'd2;
  localparam logic [2:0] S_A2     = 3'd3;
  localparam logic [2:0] S_B2     = 3'd4;
  localparam logic [2:0] S_CHARGE = 3'd5;
  localparam logic [2:0] S_DEAD   = 3'd6;

  localparam logic [1:0] LD_NONE = 2'd0;
  localparam logic [1:0] LD_A    = 2'd1;
  localparam logic [1:0] LD_B    = 2'd2;
  localparam logic [1:0] LD_BEAM = 2'd3;

  localparam int OFF = BOSS_W / (N_PROJ - 1);
  // Sums are defined at 11 bits then truncated; truncating straight to the
  // port width gives the same low bits.
  localparam logic [8:0] PY = 9'(BOSS_Y + BOSS_H);

  // Counter holds 0..BEAM_DELAY-1 while charging.
  localparam int CW = (BEAM_DELAY > 1) ? $clog2(BEAM_DELAY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BEAM_DELAY - 1);

  localparam logic [HP_W-1:0] HP_INIT = HP_W'(BOSS_HP);
  localparam logic [HP_W-1:0] DMG     = HP_W'(HIT_DMG);
  localparam logic [HP_W-1:0] ENR_HP  = HP_W'(ENRAGE_HP);

  localparam logic [N_PROJ-1:0] VLD_A    = '1;
  localparam logic [N_PROJ-1:0] VLD_B    = {1'b0, {(N_PROJ-1){1'b1}}};
  localparam logic [N_PROJ-1:0] VLD_BEAM = N_PROJ'(2'b11);

  typedef logic [N_PROJ-1:0][9:0] xvec_t;
  typedef logic [N_PROJ-1:0][8:0] yvec_t;

  // Constant per-channel geometry for the three attack patterns.
  xvec_t ax, bx, mx;
  yvec_t ay, by, my;

  for (genvar g = 0; g < N_PROJ; g++) begin : g_geom
    localparam logic [9:0] AX  = 10'(BOSS_X + g*OFF - PROJ_W/2);
    localparam logic [9:0] BX  = 10'(BOSS_X + OFF/2 + g*OFF - PROJ_W/2);
    localparam logic [9:0] MX0 = 10'(BOSS_X + BOSS_W/4 - BEAM_W/2);
    localparam logic [9:0] MX1 = 10'(BOSS_X + 3*BOSS_W/4 - BEAM_W/2);
    assign ax[g] = AX;
    assign ay[g] = PY;
    assign bx[g] = (g < N_PROJ-1) ? BX : 10'd0;
    assign by[g] = (g < N_PROJ-1) ? PY : 9'd0;
    assign mx[g] = (g == 0) ? MX0 : (g == 1) ? MX1 : 10'd0;
    assign my[g] = (g < 2) ? PY : 9'd0;
  end

  logic [2:0]        state_q, state_d;
  xvec_t             x_q, x_d;
  yvec_t             y_q, y_d;
  logic [N_PROJ-1:0] v_q, v_d;
  logic [9:0]        w_q, w_d;
  logic [8:0]        h_q, h_d;
  logic [1:0]        type_q, type_d;
  logic              shoot_q, shoot_d;
  logic              warn_q, warn_d;
  logic              enr_q, enr_d;
  logic              dead_q, dead_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        ld;
  logic              hit_ok, fatal;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    v_d     = v_q;
    w_d     = w_q;
    h_d     = h_q;
    type_d  = type_q;
    shoot_d = 1'b0;
    warn_d  = warn_q;
    dead_d  = dead_q;
    cnt_d   = cnt_q;
    ld      = LD_NONE;

    hit_ok = bus.bossHit && (state_q != S_DEAD);
    hp_d   = hp_q;
    if (hit_ok) hp_d = (hp_q > DMG) ? (hp_q - DMG) : '0;
    fatal  = hit_ok && (hp_d == '0);
    enr_d  = (hp_d != '0) && (hp_d <= ENR_HP);

    if (fatal) begin
      // Death wins over any step or pending beam in the same cycle.
      state_d = S_DEAD;
      dead_d  = 1'b1;
      v_d     = '0;
      warn_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.pulse_stepCycle) begin state_d = S_A1; ld = LD_A; end
        S_A1:   if (bus.pulse_stepCycle) begin state_d = S_B1; ld = LD_B; end
        S_B1:   if (bus.pulse_stepCycle) begin state_d = S_A2; ld = LD_A; end
        S_A2:   if (bus.pulse_stepCycle) begin state_d = S_B2; ld = LD_B; end
        S_B2:   if (bus.pulse_stepCycle) begin
          state_d = S_CHARGE;
          ld      = LD_BEAM;
          warn_d  = 1'b1;
          cnt_d   = '0;
        end
        S_CHARGE: begin
          // Steps are ignored while charging. The beam geometry stays on
          // the bus through the fire edge so the strobe describes the beam.
          if (cnt_q == CNT_LAST) begin
            shoot_d = 1'b1;
            warn_d  = 1'b0;
            state_d = enr_d ? S_A1 : S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    case (ld)
      LD_A: begin
        x_d = ax; y_d = ay; v_d = VLD_A;
        w_d = 10'(PROJ_W); h_d = 9'(PROJ_H); type_d = 2'b00; shoot_d = 1'b1;
      end
      LD_B: begin
        x_d = bx; y_d = by; v_d = VLD_B;
        w_d = 10'(PROJ_W); h_d = 9'(PROJ_H); type_d = 2'b00; shoot_d = 1'b1;
      end
      LD_BEAM: begin
        x_d = mx; y_d = my; v_d = VLD_BEAM;
        w_d = 10'(BEAM_W); h_d = 9'(BEAM_H); type_d = 2'b01;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_master) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      v_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      type_q  <= '0;
      shoot_q <= 1'b0;
      warn_q  <= 1'b0;
      enr_q   <= 1'b0;
      dead_q  <= 1'b0;
      hp_q    <= HP_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      v_q     <= v_d;
      w_q     <= w_d;
      h_q     <= h_d;
      type_q  <= type_d;
      shoot_q <= shoot_d;
      warn_q  <= warn_d;
      enr_q   <= enr_d;
      dead_q  <= dead_d;
      hp_q    <= hp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.bossLocX   = 10'(BOSS_X);
  assign bus.bossLocY   = 9'(BOSS_Y);
  assign bus.bossWidth  = 10'(BOSS_W);
  assign bus.bossHeight = 9'(BOSS_H);
  assign bus.projX      = x_q;
  assign bus.projY      = y_q;
  assign bus.projValid  = v_q;
  assign bus.projW      = w_q;
  assign bus.projH      = h_q;
  assign bus.attackType = type_q;
  assign bus.bossShoot  = shoot_q;
  assign bus.beamWarn   = warn_q;
  assign bus.bossHP     = hp_q;
  assign bus.enraged    = enr_q;
  assign bus.bossDead   = dead_q;

endmodule

// File: tb/tb_boss_attack_sequencer.sv
module tb_boss_attack_sequencer;
  localparam int NP = 5;
  localparam int BD = 4;
  localparam int BX = 150, BY = 50, BW = 340, BH = 150;
  localparam int PW = 10, PH = 15, MW = 50, MH = 240;
  localparam int HP0 = 300, DMG = 5, ENR = 100;
  localparam int OFF = BW / (NP - 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  always #5 clk = ~clk;

  boss_attack_sequencer_if #(.N_PROJ(NP), .HP_W(10)) bus ();
  boss_attack_sequencer_if #(.N_PROJ(3), .HP_W(10)) bus2 ();

  boss_attack_sequencer #(.N_PROJ(NP), .BEAM_DELAY(BD)) dut (
    .clk_master(clk), .rst_n(rst_n), .bus(bus.slave));

  boss_attack_sequencer #(.N_PROJ(3), .BOSS_HP(12), .HIT_DMG(7), .BEAM_DELAY(2)) dut2 (
    .clk_master(clk), .rst_n(rst2_n), .bus(bus2.slave));

  int errors = 0;
  int checks = 0;

  // ---------------- reference model (attack-list view) ----------------
  int m_hp, m_pos, m_left, m_type, m_w, m_h;
  bit m_dead, m_enr, m_shoot, m_warn, m_charging;
  logic [NP-1:0][9:0] m_x;
  logic [NP-1:0][8:0] m_y;
  logic [NP-1:0]      m_v;

  function automatic void m_reset();
    m_hp = HP0; m_pos = 0; m_left = 0; m_type = 0; m_w = 0; m_h = 0;
    m_dead = 0; m_enr = 0; m_shoot = 0; m_warn = 0; m_charging = 0;
    m_x = '0; m_y = '0; m_v = '0;
  endfunction

  // kind 0 = spread A, 1 = spread B, 2 = beam
  function automatic void m_load(int kind);
    for (int i = 0; i < NP; i++) begin
      int xv; bit on;
      xv = 0; on = 0;
      if (kind == 0) begin xv = BX + i*OFF - PW/2; on = 1; end
      else if (kind == 1) begin
        if (i < NP-1) begin xv = BX + OFF/2 + i*OFF - PW/2; on = 1; end
      end else begin
        if (i == 0) begin xv = BX + BW/4 - MW/2; on = 1; end
        if (i == 1) begin xv = BX + 3*BW/4 - MW/2; on = 1; end
      end
      m_x[i] = 10'(xv);
      m_y[i] = on ? 9'(BY + BH) : 9'd0;
      m_v[i] = on;
    end
    m_type = (kind == 2) ? 1 : 0;
    m_w = (kind == 2) ? MW : PW;
    m_h = (kind == 2) ? MH : PH;
  endfunction

  function automatic void model_step(bit s, bit h, bit r);
    int kind;
    if (r) begin m_reset(); return; end
    if (h && !m_dead) begin
      m_hp = (m_hp > DMG) ? m_hp - DMG : 0;
      if (m_hp == 0) begin
        m_dead = 1; m_v = '0; m_warn = 0; m_shoot = 0; m_enr = 0; m_charging = 0;
        return;
      end
    end
    m_enr = (m_hp != 0) && (m_hp <= ENR);
    m_shoot = 0;
    if (m_dead) return;
    if (m_charging) begin
      m_left--;
      if (m_left == 0) begin
        m_charging = 0; m_warn = 0; m_shoot = 1;
        m_pos = m_enr ? 1 : 0;  // enraged skips the idle wait: already in A1
      end
    end else if (s) begin
      kind = (m_pos == 4) ? 2 : (m_pos % 2);
      m_pos++;
      m_load(kind);
      if (kind == 2) begin m_charging = 1; m_left = BD; m_warn = 1; end
      else m_shoot = 1;
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic cyc(input bit s, input bit h, input bit r);
    @(negedge clk);
    bus.pulse_stepCycle = s; bus.bossHit = h; rst_n = !r;
    @(posedge clk);
    model_step(s, h, r);
    #1;
  endtask

  task automatic cyc2(input bit s, input bit h, input bit r);
    @(negedge clk);
    bus2.pulse_stepCycle = s; bus2.bossHit = h; rst2_n = !r;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cyc(0, 0, 1); cyc(0, 1, 1);
    checks++;
    if (bus.bossHP !== 10'd300 || bus.projValid !== '0 || bus.projX !== '0 ||
        bus.projY !== '0 || bus.projW !== '0 || bus.projH !== '0 ||
        bus.attackType !== 2'b00 || bus.bossShoot !== 1'b0 || bus.beamWarn !== 1'b0 ||
        bus.enraged !== 1'b0 || bus.bossDead !== 1'b0) begin
      errors++;
      $display("FAIL reset: hp=%0d valid=%b x=%h w=%0d type=%b shoot=%b warn=%b enr=%b dead=%b, want hp=300 rest 0",
               bus.bossHP, bus.projValid, bus.projX, bus.projW, bus.attackType,
               bus.bossShoot, bus.beamWarn, bus.enraged, bus.bossDead);
    end
    checks++;
    if (bus.bossLocX !== 10'd150 || bus.bossLocY !== 9'd50 ||
        bus.bossWidth !== 10'd340 || bus.bossHeight !== 9'd150) begin
      errors++;
      $display("FAIL boss_box: got %0d,%0d,%0d,%0d want 150,50,340,150",
               bus.bossLocX, bus.bossLocY, bus.bossWidth, bus.bossHeight);
    end
  endtask

  task automatic test_spread();
    logic [NP-1:0][9:0] ea, eb;
    ea = {10'd485, 10'd400, 10'd315, 10'd230, 10'd145};
    eb = {10'd0,   10'd442, 10'd357, 10'd272, 10'd187};
    for (int k = 0; k < 4; k++) begin
      cyc(1, 0, 0);
      checks++;
      if (bus.projX !== ((k % 2) ? eb : ea) ||
          bus.projValid !== ((k % 2) ? 5'b01111 : 5'b11111) ||
          bus.projY[0] !== 9'd200 || bus.projY[3] !== 9'd200 ||
          bus.projW !== 10'd10 || bus.projH !== 9'd15 ||
          bus.attackType !== 2'b00 || bus.bossShoot !== 1'b1) begin
        errors++;
        $display("FAIL spread_step%0d: x=%h valid=%b y0=%0d w=%0d h=%0d type=%b shoot=%b",
                 k+1, bus.projX, bus.projValid, bus.projY[0], bus.projW, bus.projH,
                 bus.attackType, bus.bossShoot);
      end
      cyc(0, 0, 0);
      checks++;
      if (bus.bossShoot !== 1'b0) begin
        errors++;
        $display("FAIL spread_shoot_width%0d: shoot=%b want 0", k+1, bus.bossShoot);
      end
    end
  endtask

  task automatic test_beam();
    cyc(1, 0, 0);
    checks++;
    if (bus.beamWarn !== 1'b1 || bus.attackType !== 2'b01 || bus.projX[0] !== 10'd210 ||
        bus.projX[1] !== 10'd380 || bus.projValid !== 5'b00011 || bus.projW !== 10'd50 ||
        bus.projH !== 9'd240 || bus.bossShoot !== 1'b0) begin
      errors++;
      $display("FAIL beam_load: warn=%b type=%b x0=%0d x1=%0d valid=%b w=%0d h=%0d shoot=%b",
               bus.beamWarn, bus.attackType, bus.projX[0], bus.projX[1], bus.projValid,
               bus.projW, bus.projH, bus.bossShoot);
    end
    for (int k = 1; k <= BD; k++) begin
      cyc(1, 0, 0);  // steps during charge must be ignored
      checks++;
      if (bus.beamWarn !== (k < BD) || bus.bossShoot !== (k == BD) ||
          bus.attackType !== 2'b01) begin
        errors++;
        $display("FAIL beam_charge%0d: warn=%b shoot=%b type=%b want warn=%b shoot=%b",
                 k, bus.beamWarn, bus.bossShoot, bus.attackType, k < BD, k == BD);
      end
    end
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    checks++;
    if (bus.projValid !== 5'b11111 || bus.attackType !== 2'b00 || bus.bossShoot !== 1'b1) begin
      errors++;
      $display("FAIL beam_return_A1: valid=%b type=%b shoot=%b want 11111/00/1",
               bus.projValid, bus.attackType, bus.bossShoot);
    end
  endtask

  task automatic test_enrage();
    cyc(0, 0, 1);
    for (int k = 0; k < 39; k++) cyc(0, 1, 0);
    checks++;
    if (bus.bossHP !== 10'd105 || bus.enraged !== 1'b0) begin
      errors++;
      $display("FAIL enrage_edge105: hp=%0d enr=%b want 105/0", bus.bossHP, bus.enraged);
    end
    cyc(0, 1, 0);
    checks++;
    if (bus.bossHP !== 10'd100 || bus.enraged !== 1'b1) begin
      errors++;
      $display("FAIL enrage_100: hp=%0d enr=%b want 100/1", bus.bossHP, bus.enraged);
    end
    for (int k = 0; k < 5; k++) cyc(1, 0, 0);
    for (int k = 0; k < BD; k++) cyc(0, 0, 0);
    checks++;
    if (bus.bossShoot !== 1'b1) begin
      errors++;
      $display("FAIL enrage_fire: shoot=%b want 1", bus.bossShoot);
    end
    cyc(1, 0, 0);  // already in A1, so the next volley is spread B
    checks++;
    if (bus.projValid !== 5'b01111 || bus.projX[0] !== 10'd187 || bus.bossShoot !== 1'b1) begin
      errors++;
      $display("FAIL enrage_skip_idle: valid=%b x0=%0d shoot=%b want 01111/187/1",
               bus.projValid, bus.projX[0], bus.bossShoot);
    end
  endtask

  task automatic test_fatal_charge();
    bit shot;
    cyc(0, 0, 1);
    for (int k = 0; k < 59; k++) cyc(0, 1, 0);
    for (int k = 0; k < 5; k++) cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 0);  // HP 5 == HIT_DMG -> 0 mid-charge
    checks++;
    if (bus.bossHP !== 10'd0 || bus.bossDead !== 1'b1 || bus.beamWarn !== 1'b0 ||
        bus.projValid !== '0 || bus.bossShoot !== 1'b0 || bus.enraged !== 1'b0) begin
      errors++;
      $display("FAIL fatal_charge: hp=%0d dead=%b warn=%b valid=%b shoot=%b enr=%b",
               bus.bossHP, bus.bossDead, bus.beamWarn, bus.projValid, bus.bossShoot, bus.enraged);
    end
    shot = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      if (bus.bossShoot !== 1'b0 || bus.bossDead !== 1'b1 || bus.bossHP !== 10'd0 ||
          bus.projValid !== '0) shot = 1;
    end
    checks++;
    if (shot) begin
      errors++;
      $display("FAIL dead_hold: shoot=%b dead=%b hp=%0d valid=%b want 0/1/0/0",
               bus.bossShoot, bus.bossDead, bus.bossHP, bus.projValid);
    end
  endtask

  task automatic test_reset_mid_charge();
    cyc(0, 0, 1);
    for (int k = 0; k < 5; k++) cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 1, 1);
    checks++;
    if (bus.bossHP !== 10'd300 || bus.beamWarn !== 1'b0 || bus.projValid !== '0 ||
        bus.projX !== '0 || bus.attackType !== 2'b00 || bus.projW !== '0 ||
        bus.bossShoot !== 1'b0 || bus.bossDead !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_charge: hp=%0d warn=%b valid=%b type=%b w=%0d shoot=%b dead=%b",
               bus.bossHP, bus.beamWarn, bus.projValid, bus.attackType, bus.projW,
               bus.bossShoot, bus.bossDead);
    end
  endtask

  task automatic test_small_saturate();
    cyc2(0, 0, 1);
    cyc2(1, 0, 0);
    checks++;
    if (bus2.projValid !== 3'b111 || bus2.projX[0] !== 10'd145 ||
        bus2.projX[1] !== 10'd315 || bus2.projX[2] !== 10'd485) begin
      errors++;
      $display("FAIL small_spreadA: valid=%b x=%0d,%0d,%0d want 111 145,315,485",
               bus2.projValid, bus2.projX[0], bus2.projX[1], bus2.projX[2]);
    end
    cyc2(0, 1, 0);
    checks++;
    if (bus2.bossHP !== 10'd5 || bus2.enraged !== 1'b1 || bus2.bossDead !== 1'b0) begin
      errors++;
      $display("FAIL small_hit: hp=%0d enr=%b dead=%b want 5/1/0",
               bus2.bossHP, bus2.enraged, bus2.bossDead);
    end
    cyc2(1, 1, 0);  // fatal hit with a step: step ignored
    checks++;
    if (bus2.bossHP !== 10'd0 || bus2.bossDead !== 1'b1 || bus2.projValid !== 3'b000 ||
        bus2.bossShoot !== 1'b0 || bus2.enraged !== 1'b0) begin
      errors++;
      $display("FAIL small_saturate: hp=%0d dead=%b valid=%b shoot=%b enr=%b want 0/1/000/0/0",
               bus2.bossHP, bus2.bossDead, bus2.projValid, bus2.bossShoot, bus2.enraged);
    end
    cyc2(0, 1, 0);
    cyc2(1, 0, 0);
    checks++;
    if (bus2.bossHP !== 10'd0 || bus2.bossDead !== 1'b1 || bus2.projValid !== 3'b000 ||
        bus2.bossShoot !== 1'b0) begin
      errors++;
      $display("FAIL small_dead_hold: hp=%0d dead=%b valid=%b shoot=%b",
               bus2.bossHP, bus2.bossDead, bus2.projValid, bus2.bossShoot);
    end
  endtask

  task automatic test_random();
    int nbad;
    nbad = 0;
    cyc(0, 0, 1);
    for (int n = 0; n < 1500; n++) begin
      cyc(1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 99) < 6),
          1'($urandom_range(0, 199) == 0));
      checks++;
      if (bus.projX !== m_x || bus.projY !== m_y || bus.projValid !== m_v ||
          bus.projW !== 10'(m_w) || bus.projH !== 9'(m_h) || bus.attackType !== 2'(m_type)) begin
        errors++;
        if (nbad < 10)
          $display("FAIL rand_geom@%0d: x=%h valid=%b w=%0d type=%b want x=%h valid=%b w=%0d type=%0d",
                   n, bus.projX, bus.projValid, bus.projW, bus.attackType, m_x, m_v, m_w, m_type);
        nbad++;
      end
      checks++;
      if (bus.bossShoot !== m_shoot || bus.beamWarn !== m_warn || bus.bossHP !== 10'(m_hp) ||
          bus.enraged !== m_enr || bus.bossDead !== m_dead) begin
        errors++;
        if (nbad < 10)
          $display("FAIL rand_status@%0d: shoot=%b warn=%b hp=%0d enr=%b dead=%b want %b %b %0d %b %b",
                   n, bus.bossShoot, bus.beamWarn, bus.bossHP, bus.enraged, bus.bossDead,
                   m_shoot, m_warn, m_hp, m_enr, m_dead);
        nbad++;
      end
    end
  endtask

  initial begin
    bus.pulse_stepCycle = 1'b0; bus.bossHit = 1'b0;
    bus2.pulse_stepCycle = 1'b0; bus2.bossHit = 1'b0;
    m_reset();
    test_reset();
    test_spread();
    test_beam();
    test_enrage();
    test_fatal_charge();
    test_reset_mid_charge();
    test_small_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/boss_attack_sequencer.md
Name: boss_attack_sequencer

Overview:
Parametrised boss attack generator for the game core. It replaces the fixed five-projectile boss controller with a generalised version that adds:
- N_PROJ projectile channels with per-channel valid bits.
- A timed beam attack with a charge warning.
- Saturating HP with a death state.
- An enraged mode that shortens the attack cycle.

It sits between the game step-pulse generator, the collision unit (which drives bossHit) and the renderer/projectile movers (which consume the geometry buses and bossShoot).

Parameters:
N_PROJ, 5, projectile channel count; N_PROJ >= 3
BOSS_X, 150, boss left edge (px)
BOSS_Y, 50, boss top edge (px)
BOSS_W, 340, boss width (px)
BOSS_H, 150, boss height (px)
PROJ_W, 10, projectile width
PROJ_H, 15, projectile height
BEAM_W, 50, beam width
BEAM_H, 240, beam height
BEAM_DELAY, 25000000, clk_master cycles from beam warning to beam fire; >= 1
BOSS_HP, 300, initial HP
HIT_DMG, 5, HP removed per hit
ENRAGE_HP, 100, enraged when 0 < HP <= ENRAGE_HP
HP_W, 10, HP width

Ports:
clk_master  in  1  system clock
rst_n  in  1  synchronous active-low reset
pulse_stepCycle  in  1  one-cycle attack-step pulse
bossHit  in  1  one-cycle hit pulse from collision unit
bossLocX  out  10  BOSS_X constant
bossLocY  out  9  BOSS_Y constant
bossWidth  out  10  BOSS_W constant
bossHeight  out  9  BOSS_H constant
projX  out  10*N_PROJ  channel i X at bits [10i+9:10i]
projY  out  9*N_PROJ  channel i Y at bits [9i+8:9i]
projValid  out  N_PROJ  channel i active
projW  out  10  current object width
projH  out  9  current object height
attackType  out  2  00 projectile, 01 beam
bossShoot  out  1  one-cycle fire strobe
beamWarn  out  1  beam charging
bossHP  out  HP_W  current HP
enraged  out  1  enraged flag
bossDead  out  1  HP reached 0

Behaviour:
- Only clk_master rising edges are used. rst_n low at an edge overrides every other input.
- Reset values:
  - projX, projY, projValid, projW, projH, attackType: 0.
  - bossShoot, beamWarn, enraged, bossDead: 0.
  - bossHP: BOSS_HP.
  - FSM state: IDLE.
- Geometry:
  - OFF = BOSS_W/(N_PROJ-1), integer division. PY = BOSS_Y+BOSS_H.
  - SPREAD_A: channel i = 0..N_PROJ-1 gets X = BOSS_X + i*OFF - PROJ_W/2, Y = PY, all valid.
  - SPREAD_B: channel i = 0..N_PROJ-2 gets X = BOSS_X + OFF/2 + i*OFF - PROJ_W/2, Y = PY, valid. The last channel gets X = Y = 0, invalid.
  - BEAM: channel 0 gets X = BOSS_X + BOSS_W/4 - BEAM_W/2; channel 1 gets X = BOSS_X + 3*BOSS_W/4 - BEAM_W/2; both Y = PY, valid. Channels >= 2 are 0 and invalid. projW/projH = BEAM_W/BEAM_H.
  - For SPREAD_A and SPREAD_B, projW/projH = PROJ_W/PROJ_H.
  - All sums are computed at 11 bits and truncated to the port width.
- FSM states: IDLE, A1, B1, A2, B2, CHARGE, DEAD. A step pulse sampled at edge T moves the FSM and registers new outputs at T.
  - IDLE: step -> A1.
  - A1: step -> B1. A2: step -> B2.
  - B1: step -> A2.
  - B2: step -> CHARGE. Beam geometry is loaded, attackType = 01, beamWarn = 1, the cycle counter is cleared.
  - CHARGE: pulse_stepCycle is ignored. The counter increments each cycle. At the edge where BEAM_DELAY cycles have elapsed since beamWarn rose, bossShoot = 1 for that cycle, beamWarn = 0, and the FSM goes to IDLE (A1 if enraged).
  - Entering A1/A2 or B1/B2 loads SPREAD_A or SPREAD_B respectively, attackType = 00, bossShoot = 1 at the same edge.
  - bossShoot is otherwise 0, so it is exactly one cycle wide.
- HP:
  - bossHit when HP > HIT_DMG: HP -= HIT_DMG.
  - bossHit when HP <= HIT_DMG: HP = 0 (saturate).
  - bossHit is ignored in DEAD.
  - enraged = (HP != 0) && (HP <= ENRAGE_HP), registered from the updated HP.
- Death:
  - The edge at which HP becomes 0 sets bossDead = 1, FSM = DEAD, and clears projValid, beamWarn and bossShoot. This holds even mid-CHARGE; no beam fires.
  - A step pulse coinciding with the fatal hit is ignored.
  - DEAD is left only through reset.
- A hit and a step in the same cycle are both processed, unless the hit is fatal.

Test Plan:
- Reset, then 5 steps with defaults -> after step 1: projX ch0..4 = 145, 230, 315, 400, 485, projY = 200, valid = 11111, bossShoot high exactly one cycle. Step 2: ch0..3 = 187, 272, 357, 442, valid = 01111. Steps 3–4 repeat A then B.
- Step 5 with BEAM_DELAY = 4 -> beamWarn high 4 cycles, ch0 X = 210, ch1 X = 380, projW = 50, projH = 240, attackType = 01. bossShoot pulses at the edge beamWarn falls. Extra steps during charge are ignored. Next step returns to A1.
- 40 hits -> HP 300 -> 100, enraged = 1 when HP = 100. After the beam, FSM goes straight to A1 with no idle step.
- HIT_DMG = 7 with HP = 5, then one hit -> HP = 0 (no wrap), bossDead = 1, projValid = 0. Further hits and steps cause no change.
- Fatal hit during CHARGE -> beamWarn clears, bossShoot never asserts.
- rst_n low mid-CHARGE, asserted together with bossHit -> all outputs return to reset values, HP = 300.
